seq_logic32: RTL and testbench

- Multi-cycle 32-bit bitwise logic unit. It takes two operands and an opcode, processes CHUNK bits per clock, and returns the registered result with a one-cycle done pulse.
- It is the sequential counterpart to the single-cycle combinational bitwise elements.
- It sits behind the lab ALU/datapath as a start/done-handshaked execution element, and is used to exercise FSM control in the lab flow.

---
 rtl/seq_logic32.sv | 199 +++++++++++++++++++
 tb/tb_seq_logic32.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_logic32.sv
// ---------------------------------------------------------------------------
// seq_logic32
//
// Multi-cycle bitwise logic unit. It is the sequential counterpart to the
// single-cycle combinational bitwise elements. When start is seen in IDLE it
// latches two operands and an opcode. It then works through the operands
// CHUNK bits per clock, over NSTEP RUN cycles. Finally it presents the full
// result on res with a one-cycle done pulse.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous, active-low reset
//   start  in   1      request, only looked at while IDLE
//   op     in   3      operation select, latched with start
//                        000 AND, 001 OR, 010 XOR, 011 NOR, 100 ANDN,
//                        101..111 behave as AND
//   A      in   WIDTH  operand A, latched with start
//   B      in   WIDTH  operand B, latched with start
//   busy   out  1      high while RUN or DONE
//   done   out  1      one-cycle pulse in the cycle res becomes valid
//   res    out  WIDTH  registered result, held until the next completion
//   zero   out  1      registered, 1 when res == 0, updated with res
//
// Timing: start is accepted at edge E0. RUN edges E1..E8 each fold in one
// chunk (for NSTEP = 8). res, zero and done update at E8. The unit returns
// to IDLE at E9, so busy is high for NSTEP+1 cycles.
// ---------------------------------------------------------------------------
module seq_logic32 #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             zero
);

    // NSTEP is derived from WIDTH and CHUNK and is never set on its own.
    localparam int NSTEP = WIDTH / CHUNK;

    // The step counter needs at least one bit, even for a degenerate
    // single-step build.
    localparam int CW = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(NSTEP - 1);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_ANDN = 3'b100;

    // A partial last chunk would leave result bits that are never computed.
    if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : gBadChunk
        $error("seq_logic32: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] opA_q;
    logic [WIDTH-1:0] opB_q;
    logic [2:0]       opSel_q;
    logic [WIDTH-1:0] accum_q;
    logic [WIDTH-1:0] res_q;
    logic             zero_q;
    logic             busy_q;
    logic             done_q;

    logic [CHUNK-1:0] aChunk;
    logic [CHUNK-1:0] bChunk;
    logic [CHUNK-1:0] chunkRes;
    logic [WIDTH-1:0] accum_d;

    // Applies the latched operation to one chunk. Undefined opcodes fall
    // back to AND on purpose; no error is flagged for them.
    function automatic logic [CHUNK-1:0] applyOp(
        input logic [2:0]       sel,
        input logic [CHUNK-1:0] a,
        input logic [CHUNK-1:0] b
    );
        logic [CHUNK-1:0] r;
        case (sel)
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_ANDN: r = a & ~b;
            OP_AND:  r = a & b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // Selects the chunk of the latched operands for the current step. The
    // chunk result is merged into a copy of the accumulator. The merged
    // value (accum_d) is what the final step commits to res. This keeps the
    // last chunk from costing an extra cycle. A loop with constant slices
    // is used rather than a variable part-select, so every slice index is
    // fixed at elaboration.
    always_comb begin
        aChunk  = '0;
        bChunk  = '0;
        for (int s = 0; s < NSTEP; s++) begin
            if (cnt_q == CW'(s)) begin
                aChunk = opA_q[s*CHUNK +: CHUNK];
                bChunk = opB_q[s*CHUNK +: CHUNK];
            end
        end

        chunkRes = applyOp(opSel_q, aChunk, bChunk);

        accum_d = accum_q;
        for (int s = 0; s < NSTEP; s++) begin
            if (cnt_q == CW'(s)) begin
                accum_d[s*CHUNK +: CHUNK] = chunkRes;
            end
        end
    end

    // Control FSM with registered outputs.
    // - IDLE latches the request.
    // - RUN walks the counter through NSTEP chunks. On the last step it
    //   commits the merged result together with zero and done.
    // - DONE holds for exactly one cycle, then returns to IDLE.
    // res and zero are only written at completion, so partial results are
    // never visible. The counter is not advanced on the last step. This
    // means its wrap is never exercised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opA_q   <= '0;
            opB_q   <= '0;
            opSel_q <= '0;
            accum_q <= '0;
            res_q   <= '0;
            zero_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        opA_q   <= A;
                        opB_q   <= B;
                        opSel_q <= op;
                        accum_q <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end

                RUN: begin
                    accum_q <= accum_d;
                    if (cnt_q == LAST_STEP) begin
                        res_q   <= accum_d;
                        zero_q  <= (accum_d == '0);
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end

                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign res  = res_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_seq_logic32.sv
// ---------------------------------------------------------------------------
// tb_seq_logic32
//
// Scoreboard bench for seq_logic32.
//
// Reference model:
// - Each accepted request pushes the expected result into a queue. The
//   result is computed with whole-word operators.
// - A cycle count of remaining busy time gives the expected busy/done
//   timing and the expected held res/zero values.
//
// Monitor:
// - Runs on every falling edge.
// - Compares busy/done/res/zero against the model.
// - Pops the queue whenever done is seen.
// ---------------------------------------------------------------------------
module tb_seq_logic32;

    localparam int WIDTH = 32;
    localparam int CHUNK = 4;
    localparam int NSTEP = WIDTH / CHUNK;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [2:0]        op;
    logic [WIDTH-1:0]  A;
    logic [WIDTH-1:0]  B;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  res;
    logic              zero;

    int                vecCount  = 0;
    int                missCount = 0;

    logic [WIDTH-1:0]  expQ[$];
    int                mBusyCnt  = 0;
    logic [WIDTH-1:0]  mPending  = '0;
    logic [WIDTH-1:0]  mRes      = '0;
    logic              mZero     = 1'b1;

    seq_logic32 #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .res   (res),
        .zero  (zero)
    );

    // 10-unit clock period; rising edges fall at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Whole-word reference for each opcode; unused codes act as AND.
    function automatic logic [WIDTH-1:0] refOp(
        input logic [2:0]       sel,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        case (sel)
            3'b001:  return a | b;
            3'b010:  return a ^ b;
            3'b011:  return ~(a | b);
            3'b100:  return a & ~b;
            default: return a & b;
        endcase
    endfunction

    // One counted comparison. It is automatic because the monitor and the
    // stimulus both call it on the same edge.
    task automatic checkOutput(
        input string            name,
        input logic [WIDTH-1:0] actual,
        input logic [WIDTH-1:0] expected
    );
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Reference timing model.
    // - An accepted request keeps the unit busy for NSTEP+1 cycles.
    // - The final busy cycle is the done cycle. In that cycle the pending
    //   result becomes the held res/zero.
    // - Reset drops everything, including queued expectations, so an
    //   aborted operation must never produce a done.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusyCnt = 0;
            mRes     = '0;
            mZero    = 1'b1;
            expQ.delete();
        end else if (mBusyCnt == 0) begin
            if (start === 1'b1) begin
                mPending = refOp(op, A, B);
                expQ.push_back(mPending);
                mBusyCnt = NSTEP + 1;
            end
        end else begin
            mBusyCnt--;
            if (mBusyCnt == 1) begin
                mRes  = mPending;
                mZero = (mPending == '0);
            end
        end
    end

    // Monitor.
    // - Every falling edge: check busy/done timing and the held res/zero.
    // - On done: pop the scoreboard and check the completed result.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checkOutput("busy", WIDTH'(busy), WIDTH'(mBusyCnt > 0));
            checkOutput("done", WIDTH'(done), WIDTH'(mBusyCnt == 1));
            checkOutput("res_hold", res, mRes);
            checkOutput("zero_hold", WIDTH'(zero), WIDTH'(mZero));
            if (done === 1'b1) begin
                if (expQ.size() == 0) begin
                    vecCount++;
                    missCount++;
                    $display("[TB] FAIL sb_unexpected_done: got done=1, expected no pending result at %0t",
                             $time);
                end else begin
                    logic [WIDTH-1:0] exp;
                    exp = expQ.pop_front();
                    checkOutput("sb_res", res, exp);
                    checkOutput("sb_zero", WIDTH'(zero), WIDTH'(exp == '0));
                end
            end
        end
    end

    // Issues one request, with start held high for 'hold' cycles. After
    // acceptance it scrambles A/B/op, which the unit must ignore. It then
    // waits, with a bound, for the model to go idle. doneAt is the index of
    // the falling edge carrying done. Index 0 is the falling edge just after
    // the accepting edge.
    task automatic applyStimulus(
        input  logic [2:0]       opIn,
        input  logic [WIDTH-1:0] aIn,
        input  logic [WIDTH-1:0] bIn,
        input  int               hold,
        output int               doneAt
    );
        bit finished;
        finished = 1'b0;
        doneAt   = -1;
        start    = 1'b1;
        op       = opIn;
        A        = aIn;
        B        = bIn;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                A  = $urandom;
                B  = $urandom;
                op = 3'($urandom_range(0, 7));
            end
            if (cyc == hold - 1) start = 1'b0;
            if (done === 1'b1 && doneAt < 0) doneAt = cyc;
            if (cyc >= hold - 1 && mBusyCnt == 0) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) begin
            start = 1'b0;
            vecCount++;
            missCount++;
            $display("[TB] FAIL op_timeout: got no completion, expected idle within 60 cycles");
        end
    endtask

    // Opcode sweep table, shared operands A=F0F0AAAA, B=FF00CCCC.
    logic [2:0]       sweepOp [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
    logic [WIDTH-1:0] sweepRes[5] = '{32'hFFF0EEEE, 32'h0FF06666, 32'h000F1111,
                                      32'h00F02222, 32'hF0008888};

    initial begin
        int doneAt;
        int doneIdx[$];
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        rst_n = 1'b1;
        start = 1'b0;
        op    = '0;
        A     = '0;
        B     = '0;

        // Reset asserted between clock edges must clear outputs at once.
        #3 rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", WIDTH'(busy), '0);
        checkOutput("rst_done", WIDTH'(done), '0);
        checkOutput("rst_res",  res, '0);
        checkOutput("rst_zero", WIDTH'(zero), WIDTH'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_res",  res, '0);
        checkOutput("idle_zero", WIDTH'(zero), WIDTH'(1));

        // AND with latency check.
        applyStimulus(3'b000, 32'hFFFF0000, 32'h0F0F0F0F, 1, doneAt);
        checkOutput("and_res",     res, 32'h0F0F0000);
        checkOutput("and_zero",    WIDTH'(zero), '0);
        checkOutput("and_latency", WIDTH'(doneAt), WIDTH'(NSTEP));

        // Opcode sweep.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(sweepOp[i], 32'hF0F0AAAA, 32'hFF00CCCC, 1, doneAt);
            checkOutput($sformatf("sweep_op%0d", sweepOp[i]), res, sweepRes[i]);
            checkOutput($sformatf("sweep_zero%0d", sweepOp[i]), WIDTH'(zero), '0);
        end

        // Zero flag, with A scrambled after acceptance.
        applyStimulus(3'b010, 32'h12345678, 32'h12345678, 1, doneAt);
        checkOutput("xor_zero_res",  res, '0);
        checkOutput("xor_zero_flag", WIDTH'(zero), WIDTH'(1));

        // Start held high: exactly two completions, 10 cycles apart.
        start = 1'b1;
        op    = 3'b001;
        A     = 32'h1;
        B     = 32'h2;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) doneIdx.push_back(i);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("b2b_count", WIDTH'(doneIdx.size()), WIDTH'(2));
        if (doneIdx.size() == 2)
            checkOutput("b2b_gap", WIDTH'(doneIdx[1] - doneIdx[0]), WIDTH'(NSTEP + 2));
        checkOutput("b2b_res", res, 32'h3);

        // Reset after four RUN edges: outputs clear at once and the
        // aborted operation never pulses done.
        start = 1'b1;
        op    = 3'b000;
        A     = 32'hFFFFFFFF;
        B     = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", WIDTH'(busy), '0);
        checkOutput("abort_done", WIDTH'(done), '0);
        checkOutput("abort_res",  res, '0);
        checkOutput("abort_zero", WIDTH'(zero), WIDTH'(1));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (NSTEP + 2) @(negedge clk);
        applyStimulus(3'b100, 32'hDEADBEEF, 32'h0000FFFF, 1, doneAt);
        checkOutput("post_abort_res", res, 32'hDEAD0000);

        // Randomised traffic. Some requests hold start into the busy period.
        // Roughly one in four forces an XOR of equal operands to exercise
        // zero.
        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0)
                applyStimulus(3'b010, ra, ra, int'($urandom_range(1, 3)), doneAt);
            else
                applyStimulus(3'($urandom_range(0, 7)), ra, rb, int'($urandom_range(1, 3)), doneAt);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        checkOutput("sb_drained", WIDTH'(expQ.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
